// File: rtl/demux_lane_sched.sv
// Serial-to-parallel lane demultiplexer.
// Accepted bytes are distributed round-robin over four lane registers. A group
// closes either when lane 3 is written (full) or when the stream pauses
// mid-group (partial, via a one-cycle flush state). Each close emits a
// one-cycle group_done pulse with the valid-lane mask and bumps group_cnt.
module demux_lane_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic [3:0] out_valid,
    output logic [1:0] lane_sel,
    output logic       group_done,
    output logic [3:0] group_mask,
    output logic [7:0] group_cnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } state_e;

    state_e     state_q;
    logic [7:0] data_q [4];
    logic [3:0] out_valid_q;
    logic [1:0] lane_sel_q;
    logic       group_done_q;
    logic [3:0] group_mask_q;
    logic [7:0] group_cnt_q;

    logic       accept;
    logic [1:0] wr_lane;
    logic [3:0] valid_upd;

    // Byte acceptance, target lane and the resulting lane-valid bits.
    always_comb begin
        accept  = enable & valid_in;
        // Only RUN continues a group; IDLE and FLUSH always start at lane 0.
        wr_lane = (state_q == StRun) ? lane_sel_q : 2'd0;
        if (wr_lane == 2'd0) begin
            valid_upd = 4'b0001;
        end else begin
            valid_upd = out_valid_q | (4'b0001 << wr_lane);
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            data_q[0]    <= 8'h00;
            data_q[1]    <= 8'h00;
            data_q[2]    <= 8'h00;
            data_q[3]    <= 8'h00;
            out_valid_q  <= 4'b0000;
            lane_sel_q   <= 2'd0;
            group_done_q <= 1'b0;
            group_mask_q <= 4'b0000;
            group_cnt_q  <= 8'h00;
        end else begin
            group_done_q <= 1'b0;
            if (accept) begin
                data_q[wr_lane] <= data_in;
                out_valid_q     <= valid_upd;
                lane_sel_q      <= wr_lane + 2'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) state_q <= StRun;
                end
                StRun: begin
                    if (accept) begin
                        if (lane_sel_q == 2'd3) begin
                            group_done_q <= 1'b1;
                            group_mask_q <= 4'b1111;
                            group_cnt_q  <= group_cnt_q + 8'd1;
                        end
                    end else if (lane_sel_q != 2'd0) begin
                        state_q <= StFlush;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StFlush: begin
                    // Mask uses the pre-edge valid bits, before any lane-0 restart.
                    group_done_q <= 1'b1;
                    group_mask_q <= out_valid_q;
                    group_cnt_q  <= group_cnt_q + 8'd1;
                    if (accept) begin
                        state_q <= StRun;
                    end else begin
                        lane_sel_q <= 2'd0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_out0  = data_q[0];
    assign data_out1  = data_q[1];
    assign data_out2  = data_q[2];
    assign data_out3  = data_q[3];
    assign out_valid  = out_valid_q;
    assign lane_sel   = lane_sel_q;
    assign group_done = group_done_q;
    assign group_mask = group_mask_q;
    assign group_cnt  = group_cnt_q;

endmodule

// File: tb/tb_demux_lane_sched.sv
// Self-checking bench for demux_lane_sched. Expected group closes (mask, count)
// are queued when stimulus is driven and popped by a monitor on each pulse.
module tb_demux_lane_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       valid_in;
    logic [7:0] data_in;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic [3:0] out_valid;
    logic [1:0] lane_sel;
    logic       group_done;
    logic [3:0] group_mask;
    logic [7:0] group_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_cnt;
    logic [11:0] exp_q [$];   // {mask, cnt}

    demux_lane_sched dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .out_valid  (out_valid),
        .lane_sel   (lane_sel),
        .group_done (group_done),
        .group_mask (group_mask),
        .group_cnt  (group_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (group_done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_group_done mask=%b cnt=%0d, required no pulse",
                         group_mask, group_cnt);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({group_mask, group_cnt} !== e) begin
                    errors++;
                    $display("FAIL group_pulse mask=%b cnt=%0d, required mask=%b cnt=%0d",
                             group_mask, group_cnt, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic drive(input logic en, input logic v, input logic [7:0] d);
        enable   = en;
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_close(input logic [3:0] mask);
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back({mask, exp_cnt});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'hAB);
        reset   = 1'b0;
        exp_cnt = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({data_out0, data_out1, data_out2, data_out3, out_valid, lane_sel, group_done,
             group_mask, group_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state d=%h %h %h %h ov=%b ls=%0d gd=%b gm=%b gc=%0d, required all 0",
                     data_out0, data_out1, data_out2, data_out3, out_valid, lane_sel,
                     group_done, group_mask, group_cnt);
        end
    endtask

    task automatic test_full_group();
        do_reset();
        drive(1'b1, 1'b1, 8'hFF); chk("fg_ls1", lane_sel, 1);
        drive(1'b1, 1'b1, 8'hDD); chk("fg_ls2", lane_sel, 2);
        drive(1'b1, 1'b1, 8'hEE); chk("fg_ls3", lane_sel, 3);
        chk("fg_nodone", group_done, 0);
        expect_close(4'b1111);
        drive(1'b1, 1'b1, 8'hCC);
        chk("fg_done", group_done, 1);
        chk("fg_data", {data_out0, data_out1, data_out2, data_out3}, 32'hFFDDEECC);
        chk("fg_valid", out_valid, 4'b1111);
        chk("fg_cnt", group_cnt, 1);
        chk("fg_ls0", lane_sel, 0);
        drive(1'b1, 1'b0, 8'h00);
        chk("fg_pulse_end", group_done, 0);
        chk("fg_hold", {data_out0, data_out3, 4'h0, out_valid}, {8'hFF, 8'hCC, 8'h0F});
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [8];
        b = '{8'hFF, 8'hDD, 8'hEE, 8'hCC, 8'hBB, 8'h99, 8'hAA, 8'h88};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) expect_close(4'b1111);
            drive(1'b1, 1'b1, b[i]);
            chk($sformatf("b2b_done%0d", i), group_done, (i % 4 == 3) ? 1 : 0);
            if (i == 4) begin
                chk("b2b_valid_bb", out_valid, 4'b0001);
                chk("b2b_data_bb", {data_out0, data_out1, data_out2, data_out3}, 32'hBBDDEECC);
            end
        end
        chk("b2b_cnt", group_cnt, 2);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 1'b1, 8'h77);
        drive(1'b1, 1'b1, 8'h88);
        drive(1'b1, 1'b0, 8'h00);   // enters FLUSH
        chk("fl_no_early", group_done, 0);
        expect_close(4'b0011);
        drive(1'b1, 1'b0, 8'h00);
        chk("fl_done", group_done, 1);
        chk("fl_ls", lane_sel, 0);
        chk("fl_cnt", group_cnt, 1);
        chk("fl_hold", {data_out0, data_out1, 4'h0, out_valid}, {8'h77, 8'h88, 8'h03});
        drive(1'b1, 1'b0, 8'h00);
        chk("fl_idle", {group_done, lane_sel}, 0);
    endtask

    task automatic test_flush_restart();
        do_reset();
        drive(1'b1, 1'b1, 8'h11);
        drive(1'b1, 1'b1, 8'h22);
        drive(1'b1, 1'b1, 8'h33);
        drive(1'b1, 1'b0, 8'h00);
        expect_close(4'b0111);
        drive(1'b1, 1'b1, 8'h44);
        chk("fr_done", group_done, 1);
        chk("fr_data", {data_out0, data_out1, data_out2}, 24'h442233);
        chk("fr_valid", out_valid, 4'b0001);
        chk("fr_ls", lane_sel, 1);
        drive(1'b1, 1'b0, 8'h00);
        expect_close(4'b0001);
        drive(1'b1, 1'b0, 8'h00);
        chk("fr_cnt", group_cnt, 2);
    endtask

    task automatic test_enable_drop();
        do_reset();
        drive(1'b1, 1'b1, 8'h5A);
        drive(1'b1, 1'b1, 8'hA5);
        drive(1'b0, 1'b1, 8'hEE);   // enable low acts like valid low
        expect_close(4'b0011);
        drive(1'b0, 1'b1, 8'hEF);
        chk("ed_done", group_done, 1);
        chk("ed_data2", data_out2, 8'h00);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b1, 8'h12);
        drive(1'b1, 1'b1, 8'h34);
        do_reset();
        chk("rm_state", {data_out0, data_out1, out_valid, lane_sel, group_done, group_cnt},
            {8'h00, 8'h00, 4'h0, 2'd0, 1'b0, 8'h00});
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h99);
            chk("rm_disabled", {lane_sel, out_valid, data_out0}, 0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int g = 0; g < 257; g++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) expect_close(4'b1111);
                drive(1'b1, 1'b1, 8'(g + k));
            end
            if (g == 255) chk("wrap_zero", group_cnt, 8'h00);
        end
        chk("wrap_one", group_cnt, 8'h01);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        exp_cnt  = 8'h00;
        test_reset();
        test_full_group();
        test_back_to_back();
        test_flush();
        test_flush_restart();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        chk("pulses_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_lane_sched.md
DEMUX_LANE_SCHED -- requirements
Module: demux_lane_sched

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous active-high reset.
- enable  in  1  distribution permitted when 1.
- valid_in  in  1  data_in carries a byte this cycle.
- data_in  in  8  serial byte stream.
- data_out0 .. data_out3  out  8 each  lane byte registers.
- out_valid  out  4  bit k=1: data_outk holds a byte of the current group.
- lane_sel  out  2  lane that receives the next accepted byte.
- group_done  out  1  one-cycle pulse: group closed (full or partial).
- group_mask  out  4  lanes valid in the closed group; meaningful when group_done=1.
- group_cnt  out  8  number of groups closed since reset.

Function
REQ-003 A byte SHALL be accepted in a cycle iff enable=1 and valid_in=1 and reset=0.
REQ-004 States SHALL be IDLE, RUN and FLUSH, encoded in a 2-bit register.
REQ-005 IDLE: lane_sel=0; an accepted byte -> RUN; otherwise stay IDLE.
REQ-006 Accepted byte at edge N: data_out[lane_sel] <= data_in; visible in cycle N+1 (latency 1); other data_out registers unchanged.
REQ-007 An accepted byte written to lane 0 SHALL set out_valid to 4'b0001; one written to lane k>0 SHALL set bit k and keep the other bits.
REQ-008 lane_sel SHALL increment by 1 modulo 4 on every accepted byte (3 wraps to 0).
REQ-009 Accepted byte written to lane 3: at the same edge group_done<=1, group_mask<=4'b1111, group_cnt+1; state stays RUN.
REQ-010 RUN with no accepted byte and lane_sel!=0 -> FLUSH; with lane_sel==0 -> IDLE, no pulse.
REQ-011 FLUSH (one cycle): group_done<=1, group_mask<=out_valid, group_cnt+1, lane_sel<=0; next state IDLE, no accepted byte in the FLUSH cycle.
REQ-012 An accepted byte in the FLUSH cycle SHALL also be written to lane 0 (out_valid<=4'b0001, lane_sel<=1) in the same edge as the flush pulse; next state RUN.
REQ-013 group_done SHALL be 0 in every cycle not named in REQ-009/REQ-011.
REQ-014 group_cnt SHALL wrap from 255 to 0.
REQ-015 out_valid and data_out SHALL hold after a group closes until the next accepted byte to lane 0.
REQ-016 enable falling mid-group SHALL behave exactly as valid_in falling (REQ-010).

Reset
REQ-017 reset=1 at an edge SHALL set state=IDLE, lane_sel=0, data_out0..3=8'h00, out_valid=4'b0000, group_done=0, group_mask=4'b0000, group_cnt=8'h00, overriding all other activity.
REQ-018 Reset mid-group SHALL discard the partial group with no group_done pulse and no count increment.

Verification
REQ-019 Reset, then 4 accepted bytes FF,DD,EE,CC on consecutive cycles -> data_out0..3=FF,DD,EE,CC; out_valid=1111; group_done pulse with group_mask=1111 one cycle after CC; group_cnt=1.
REQ-020 8 consecutive bytes FF,DD,EE,CC,BB,99,AA,88 -> two group_done pulses 4 cycles apart; after BB out_valid=0001, data_out0=BB, data_out1..3 still DD,EE,CC; group_cnt=2.
REQ-021 Bytes 77,88 then valid_in=0 -> FLUSH cycle: group_done=1, group_mask=0011, lane_sel=0, group_cnt+1; next cycle state IDLE.
REQ-022 Bytes 11,22,33 then valid_in=0 one cycle then 44 on the FLUSH cycle -> group_mask=0111 pulse; data_out0=44, out_valid=0001, lane_sel=1.
REQ-023 Reset asserted after 2 bytes of a group -> all outputs at reset values next cycle, no group_done; enable=0 with valid_in=1 -> no bytes accepted, lane_sel stays 0.
REQ-024 257 full groups -> group_cnt=8'h01 (wrap check).
